modn_updown_counter: RTL
========================

Name: modn_updown_counter

Overview:
Parametrised synchronous modulo-N up/down counter. It is the next generation of the team's 4-bit ripple counter.
- All state bits change on a single clock edge. There is no clock rippling between stages.
- Adds count enable, direction control, synchronous parallel load, a programmable modulus, and terminal-count/wrap outputs for cascading.
- Used as a general event/divider counter and as a building block for multi-digit (e.g. BCD) counter chains.

Parameters:
- WIDTH, 4, counter width in bits; must be at least 1.
- MODULUS, 16, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH (elaboration-time check, fatal if violated).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- clear  input  1  asynchronous active-high reset.
- en  input  1  count enable; one step per clock while high.
- up  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load; takes priority over en.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational): high when the next enabled step will wrap.
- wrap  output  1  registered one-cycle pulse on the cycle after a wrap occurred.

Behaviour:
- Reset:
  - clear high forces q=0 and wrap=0 immediately, independent of clk.
  - Held for as long as clear is high; all inputs are ignored during that time.
  - Release is synchronous-safe: the first update happens on the first rising edge after clear falls.
- Priority at each rising edge, highest first: clear, load, en.
- Load (load=1):
  - q <= d when d < MODULUS.
  - q <= MODULUS-1 when d >= MODULUS (saturate; never hold an illegal state).
  - wrap <= 0.
  - en and up are ignored that cycle.
- Count up (load=0, en=1, up=1):
  - q <= q+1.
  - When q == MODULUS-1: q <= 0 and wrap <= 1.
- Count down (load=0, en=1, up=0):
  - q <= q-1.
  - When q == 0: q <= MODULUS-1 and wrap <= 1.
- Hold (load=0, en=0): q unchanged, wrap <= 0.
- wrap is high for exactly one cycle per wrap event. It stays high on consecutive cycles only if consecutive wraps occur (possible only with MODULUS... never in normal counting; only via direction toggling at a boundary).
- tc is defined as: en & !load & ((up & q==MODULUS-1) | (!up & q==0)).
  - It is purely combinational from registered q and the inputs.
  - It feeds the en of the next stage in a cascade, so the whole chain steps on one edge.
- Direction changes take effect on the next edge with no dead cycle. Example: q=0 with up switched to 0 goes to MODULUS-1 with wrap.
- Width arithmetic:
  - Internal next-state is computed in WIDTH bits.
  - When MODULUS == 2**WIDTH, wrap-around equals natural overflow. The explicit compare must still produce the wrap pulse.
- Latency:
  - q reflects a load or step 1 cycle after the edge-sampled inputs.
  - wrap is aligned with the q value after the wrap.
  - tc has zero latency.
- Reset mid-operation (clear during a count or load): state is discarded and q=0. No wrap pulse is generated by reset or release.
- No X propagation: q must never leave 0..MODULUS-1 after reset.

Test Plan:
1. WIDTH=4, MODULUS=10: pulse clear, then en=1, up=1 for 12 cycles.
   - Required: q = 1,2,…,9,0,1,2.
   - tc high only while q=9.
   - wrap high exactly on the cycle q becomes 0.
2. MODULUS=10, q=0: en=1, up=0 for 3 cycles.
   - Required: q = 9,8,7.
   - tc high while q=0.
   - wrap pulses once when q becomes 9.
3. MODULUS=10: load=1 with d=5 and en=1, up=1 in the same cycle.
   - Required: q=5, wrap=0.
   - Then load=1 with d=13: q=9 (saturated).
4. MODULUS=10, counting up at q=4: assert clear asynchronously between edges.
   - Required: q=0 before the next edge and wrap=0.
   - After release, the first enabled edge gives q=1.
5. Cascade two MODULUS=10 instances: tc of the low stage drives en of the high stage. Count up from 0 for 100 edges.
   - Required: {high,low} steps 00→99→00 in lock-step.
   - High stage wraps exactly once.
6. WIDTH=3, MODULUS=8: count up from 7.
   - Required: q=0 and wrap=1 (natural-overflow case).
   - en=0 for 2 cycles: q holds 0 and wrap=0.

Source files
------------

// File: rtl/modn_updown_counter.sv
// Synchronous modulo-N up/down counter with enable, direction, parallel load
// and cascade outputs. Every state bit updates on the same rising clock edge.
// tc is combinational so that a chain of stages advances on one edge, and
// wrap is a registered one-cycle pulse that lines up with the wrapped q.
module modn_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Reject illegal parameter combinations while elaborating.
  // The shift form of 2**WIDTH avoids int overflow for wide counters.
  if (WIDTH < 1 || MODULUS < 2 || (WIDTH < 31 && MODULUS > (1 << WIDTH))) begin : g_bad_params
    $fatal(1, "modn_updown_counter: need WIDTH>=1 and 2<=MODULUS<=2**WIDTH");
  end

  // Highest legal count. It always fits in WIDTH bits.
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_at_top;
  logic             w_at_bottom;
  logic [WIDTH-1:0] w_d_sat;

  assign w_at_top    = (r_q == LP_MAX);
  assign w_at_bottom = (r_q == '0);

  // d >= MODULUS is the same as d > MODULUS-1. This form stays in WIDTH bits
  // even when MODULUS == 2**WIDTH.
  assign w_d_sat = (d > LP_MAX) ? LP_MAX : d;

  // The next enabled step wraps. This also feeds the next stage's enable.
  assign tc = en & ~load & ((up & w_at_top) | (~up & w_at_bottom));

  // Next count and next wrap flag. Priority is load, then en, then hold.
  always_comb begin
    // NOTE: every output of this block gets a default first. Otherwise a path
    // that leaves one unassigned would infer a latch.
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    if (load) begin
      w_q_next = w_d_sat;
    end else if (en) begin
      if (up) begin
        // The explicit compare produces the wrap pulse even when the wrap
        // coincides with natural overflow (MODULUS == 2**WIDTH).
        w_q_next    = w_at_top ? '0 : r_q + WIDTH'(1);
        w_wrap_next = w_at_top;
      end else begin
        w_q_next    = w_at_bottom ? LP_MAX : r_q - WIDTH'(1);
        w_wrap_next = w_at_bottom;
      end
    end
  end

  // State register. clear acts immediately and dominates the clock.
  always_ff @(posedge clk or posedge clear) begin
    // NOTE: state is updated with non-blocking assignments. All registers
    // then sample the values from before the edge, which removes ordering races.
    if (clear) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;

endmodule
